program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Writer side of the instruction-memory/decoder path: fills program memory before the CPU runs.
//  Takes the byte stream from the UART receiver and packs byte pairs into {opcode, operand} words.
//  Writes words to consecutive program-memory addresses from 0 and holds the CPU in reset while loading.
//  An instruction whose opcode is HLT (5'b00000) is written, then ends the load and releases the CPU.
// PARAMETERS
//  OPBTS    5   opcode width; opcode = instruction[INSBTS-1 -: OPBTS]
//  INSBTS   16  instruction width; fixed at 2*BYTBTS
//  BYTBTS   8   width of one received byte
//  ADDRBTS  11  program-memory address width (depth 2**ADDRBTS)
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  rst_n      in   1        asynchronous active-low reset
//  rx_data    in   BYTBTS   received byte, valid while rx_done=1
//  rx_done    in   1        one-cycle strobe: rx_data holds a new byte
//  reload     in   1        one-cycle pulse: discard program, restart load at address 0
//  prog_addr  out  ADDRBTS  program-memory write address
//  prog_data  out  INSBTS   program-memory write data
//  prog_we    out  1        program-memory write enable, one cycle per instruction
//  cpu_rst    out  1        active-high hold of the CPU; 1 in every state except DONE
//  load_done  out  1        1 in DONE: program complete, CPU running
//  ovf_err    out  1        sticky: memory filled with no HLT; cleared by reset or reload
//  instr_cnt  out  ADDRBTS+1  number of instructions written in this load
// BEHAVIOUR
//  Reset (async, rst_n=0): state=WAIT_HI, prog_addr=0, prog_data=0, prog_we=0, cpu_rst=1,
//   load_done=0, ovf_err=0, instr_cnt=0. Reset during any state aborts the load immediately.
//  Byte order: first byte = instruction[15:8] (opcode in [15:11]); second byte = instruction[7:0].
//  FSM:
//   WAIT_HI : on rx_done, latch rx_data into hi byte -> WAIT_LO.
//   WAIT_LO : on rx_done, drive prog_data={hi,rx_data} -> WRITE.
//   WRITE   : exactly one cycle; prog_we=1, prog_addr=current address. At exit, instr_cnt+=1, address+=1.
//             Exit to DONE if opcode==HLT; exit to DONE and set ovf_err if address==2**ADDRBTS-1;
//             otherwise exit to WAIT_HI.
//             If rx_done=1 in WRITE and the exit is not to DONE, that byte is the next hi byte -> WAIT_LO.
//   DONE    : cpu_rst=0, load_done=1; rx_done ignored; prog_we=0.
//  Latency: prog_we asserts the cycle after the low-byte rx_done strobe. cpu_rst falls the cycle after the HLT write.
//  reload (sampled in any state): next cycle state=WAIT_HI, address=0, instr_cnt=0, ovf_err=0, cpu_rst=1, load_done=0.
//   reload beats a simultaneous rx_done; the byte is dropped.
//   reload in WRITE suppresses neither that cycle's prog_we nor that cycle's write.
//  prog_we is never 1 outside WRITE. prog_addr/prog_data are stable while prog_we=1.
//  The HLT word itself is stored; instr_cnt includes it. The address does not wrap: ovf_err stops the load.
//  A half-received instruction (in WAIT_LO) when reload/reset arrives is discarded and never written.
// STRUCTURE
//  Shared package: opcode localparams (HLT,STO,LD,LDI,ADD,ADDI,SUB,SUBI) and the OPBTS/INSBTS widths.
//   The same package is used by the decoder.
//  State encoding: 2-bit localparam in this file. No sub-module: one FSM, a byte register, an address counter.
// TESTING
//  1. Reset, then send 0x18,0x05 (LDI 5) then 0x00,0x00 (HLT) -> writes addr0=0x1805, addr1=0x0000;
//     instr_cnt=2; cpu_rst falls and load_done=1 the cycle after the second prog_we.
//  2. In DONE, send 0x20,0x01 -> no prog_we, state stays DONE.
//     Then reload -> cpu_rst=1, load_done=0, next write is at addr 0.
//  3. ADDRBTS=2: send 4 non-HLT words -> 4 writes at addr 0..3, ovf_err=1, load_done=1, no 5th write.
//  4. Send 0x28 only, then reload, then 0x08,0x03,0x00,0x00 -> first write is 0x0803 at addr 0; 0x28 is never written.
//  5. Assert rx_done for the next hi byte (0x30) in the WRITE cycle of a non-HLT word, then send 0x02
//     -> next write is 0x3002 at the next address.
//  6. Drop rst_n asynchronously mid-WAIT_LO -> all outputs take reset values before the next clk edge.

Source files
------------

// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared instruction widths and opcode constants for loader and decoder
package program_loader_pkg;

    localparam int OPBTS  = 5;
    localparam int BYTBTS = 8;
    localparam int INSBTS = 2 * BYTBTS;

    localparam logic [OPBTS-1:0] OP_HLT  = 5'd0;
    localparam logic [OPBTS-1:0] OP_STO  = 5'd1;
    localparam logic [OPBTS-1:0] OP_LD   = 5'd2;
    localparam logic [OPBTS-1:0] OP_LDI  = 5'd3;
    localparam logic [OPBTS-1:0] OP_ADD  = 5'd4;
    localparam logic [OPBTS-1:0] OP_ADDI = 5'd5;
    localparam logic [OPBTS-1:0] OP_SUB  = 5'd6;
    localparam logic [OPBTS-1:0] OP_SUBI = 5'd7;

endpackage

// File: rtl/program_loader.sv
// rtl/program_loader.sv - packs received byte pairs into instruction words and writes program memory
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDRBTS = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BYTBTS-1:0]  rx_data,
    input  logic               rx_done,
    input  logic               reload,
    output logic [ADDRBTS-1:0] prog_addr,
    output logic [INSBTS-1:0]  prog_data,
    output logic               prog_we,
    output logic               cpu_rst,
    output logic               load_done,
    output logic               ovf_err,
    output logic [ADDRBTS:0]   instr_cnt
);

    localparam logic [1:0] ST_WAIT_HI = 2'd0;
    localparam logic [1:0] ST_WAIT_LO = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [ADDRBTS-1:0] ADDR_ONE = 1;
    localparam logic [ADDRBTS:0]   CNT_ONE  = 1;

    logic [1:0]         state_q, state_d;
    logic [BYTBTS-1:0]  hi_q, hi_d;
    logic [INSBTS-1:0]  data_q, data_d;
    logic [ADDRBTS-1:0] addr_q, addr_d;
    logic [ADDRBTS:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               is_hlt;
    logic               at_end;

    assign is_hlt = (data_q[INSBTS-1 -: OPBTS] == OP_HLT);
    assign at_end = (addr_q == {ADDRBTS{1'b1}});

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        data_d  = data_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_WAIT_HI: begin
                if (rx_done) begin
                    hi_d    = rx_data;
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (rx_done) begin
                    data_d  = {hi_q, rx_data};
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                cnt_d = cnt_q + CNT_ONE;
                // The last address is never incremented past: the counter must not wrap to 0.
                if (!at_end) begin
                    addr_d = addr_q + ADDR_ONE;
                end
                if (is_hlt || at_end) begin
                    state_d = ST_DONE;
                    ovf_d   = ovf_q | (at_end & ~is_hlt);
                end else if (rx_done) begin
                    hi_d    = rx_data;
                    state_d = ST_WAIT_LO;
                end else begin
                    state_d = ST_WAIT_HI;
                end
            end
            default: begin
            end
        endcase
        // reload overrides everything except the write already on the bus this cycle.
        if (reload) begin
            state_d = ST_WAIT_HI;
            addr_d  = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_HI;
            hi_q    <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign prog_addr = addr_q;
    assign prog_data = data_q;
    assign prog_we   = (state_q == ST_WRITE);
    assign cpu_rst   = (state_q != ST_DONE);
    assign load_done = (state_q == ST_DONE);
    assign ovf_err   = ovf_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized and directed bench for program_loader against a word-level model
module tb_program_loader;
    import program_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        reload;

    logic [10:0] b_addr;
    logic [15:0] b_data;
    logic        b_we, b_crst, b_ldone, b_ovf;
    logic [11:0] b_cnt;

    logic [1:0]  s_addr;
    logic [15:0] s_data;
    logic        s_we, s_crst, s_ldone, s_ovf;
    logic [2:0]  s_cnt;

    always #5 clk = ~clk;

    program_loader #(.ADDRBTS(11)) dut_big (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done), .reload(reload),
        .prog_addr(b_addr), .prog_data(b_data), .prog_we(b_we), .cpu_rst(b_crst),
        .load_done(b_ldone), .ovf_err(b_ovf), .instr_cnt(b_cnt)
    );

    program_loader #(.ADDRBTS(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done), .reload(reload),
        .prog_addr(s_addr), .prog_data(s_data), .prog_we(s_we), .cpu_rst(s_crst),
        .load_done(s_ldone), .ovf_err(s_ovf), .instr_cnt(s_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word-level reference: bytes pair up into words, words land at successive addresses.
    int m_max [2] = '{2047, 3};
    int m_addr[2];
    int m_cnt [2];
    int m_word[2];
    int m_hi  [2];
    bit m_done[2];
    bit m_ovf [2];
    bit m_wr  [2];
    bit m_have[2];

    function automatic void m_reset_one(input int i);
        m_addr[i] = 0; m_cnt[i] = 0; m_word[i] = 0; m_hi[i] = 0;
        m_done[i] = 0; m_ovf[i] = 0; m_wr[i] = 0; m_have[i] = 0;
    endfunction

    function automatic void m_step(input bit rd, input int b, input bit rl);
        bit now, hlt, full;
        for (int i = 0; i < 2; i++) begin
            now = m_wr[i];
            m_wr[i] = 0;
            if (now && !rl) begin
                hlt  = ((m_word[i] >> 11) == 0);
                full = (m_addr[i] == m_max[i]);
                m_cnt[i]++;
                if (!full) m_addr[i]++;
                if (hlt || full) m_done[i] = 1;
                if (full && !hlt) m_ovf[i] = 1;
            end
            if (rl) begin
                m_reset_one(i);
            end else if (rd && !m_done[i]) begin
                if (!m_have[i]) begin
                    m_have[i] = 1;
                    m_hi[i]   = b;
                end else begin
                    m_have[i] = 0;
                    m_word[i] = (m_hi[i] << 8) | b;
                    m_wr[i]   = 1;
                end
            end
        end
    endfunction

    task automatic check_outputs();
        chk("b_we", 32'(b_we), 32'(m_wr[0]));
        if (m_wr[0]) begin
            chk("b_addr", 32'(b_addr), 32'(m_addr[0]));
            chk("b_data", 32'(b_data), 32'(m_word[0]));
        end
        chk("b_cpu_rst", 32'(b_crst), 32'(!m_done[0]));
        chk("b_load_done", 32'(b_ldone), 32'(m_done[0]));
        chk("b_ovf", 32'(b_ovf), 32'(m_ovf[0]));
        chk("b_cnt", 32'(b_cnt), 32'(m_cnt[0]));
        chk("s_we", 32'(s_we), 32'(m_wr[1]));
        if (m_wr[1]) begin
            chk("s_addr", 32'(s_addr), 32'(m_addr[1]));
            chk("s_data", 32'(s_data), 32'(m_word[1]));
        end
        chk("s_cpu_rst", 32'(s_crst), 32'(!m_done[1]));
        chk("s_load_done", 32'(s_ldone), 32'(m_done[1]));
        chk("s_ovf", 32'(s_ovf), 32'(m_ovf[1]));
        chk("s_cnt", 32'(s_cnt), 32'(m_cnt[1]));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_b_addr"}, 32'(b_addr), 32'd0);
        chk({tag, "_b_data"}, 32'(b_data), 32'd0);
        chk({tag, "_b_we"}, 32'(b_we), 32'd0);
        chk({tag, "_b_cpu_rst"}, 32'(b_crst), 32'd1);
        chk({tag, "_b_load_done"}, 32'(b_ldone), 32'd0);
        chk({tag, "_b_ovf"}, 32'(b_ovf), 32'd0);
        chk({tag, "_b_cnt"}, 32'(b_cnt), 32'd0);
        chk({tag, "_s_cpu_rst"}, 32'(s_crst), 32'd1);
        chk({tag, "_s_cnt"}, 32'(s_cnt), 32'd0);
    endtask

    // Inputs are applied and outputs checked 1 time unit after the rising edge.
    task automatic cycle(input bit rd, input logic [7:0] b, input bit rl);
        rx_done = rd;
        rx_data = b;
        reload  = rl;
        check_outputs();
        @(posedge clk);
        m_step(rd, int'(b), rl);
        #1;
        rx_done = 1'b0;
        reload  = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        cycle(1'b1, b, 1'b0);
        repeat (gap) cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        reload  = 1'b0;
        m_reset_one(0);
        m_reset_one(1);
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        idle(2);

        // LDI 5 then HLT
        send(8'h18, 1); send(8'h05, 2); send(8'h00, 0); send(8'h00, 0);
        idle(3);
        chk("t1_cnt", 32'(b_cnt), 32'd2);
        chk("t1_load_done", 32'(b_ldone), 32'd1);

        // Bytes in DONE are ignored, then reload
        send(8'h20, 1); send(8'h01, 2);
        cycle(1'b0, 8'h00, 1'b1);
        idle(2);

        // Half word discarded by reload
        send(8'h28, 2);
        cycle(1'b0, 8'h00, 1'b1);
        send(8'h08, 0); send(8'h03, 1); send(8'h00, 1); send(8'h00, 1);
        idle(2);

        // Next hi byte arrives during the WRITE cycle
        cycle(1'b0, 8'h00, 1'b1);
        send(8'h10, 0); send(8'h07, 0);
        send(8'h30, 1); send(8'h02, 2);
        send(8'h00, 0); send(8'h00, 2);

        // Small instance overflows after four non-HLT words
        cycle(1'b0, 8'h00, 1'b1);
        for (int w = 0; w < 4; w++) begin
            send(8'h08 | 8'(w), 0);
            send(8'(w + 1), 1);
        end
        idle(3);
        chk("t3_s_ovf", 32'(s_ovf), 32'd1);
        chk("t3_s_load_done", 32'(s_ldone), 32'd1);
        chk("t3_s_cnt", 32'(s_cnt), 32'd4);
        chk("t3_b_ovf", 32'(b_ovf), 32'd0);
        send(8'h08, 0); send(8'h09, 2);

        // Randomized traffic with occasional reload
        cycle(1'b0, 8'h00, 1'b1);
        for (int c = 0; c < 1500; c++) begin
            logic [7:0] rb;
            rb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rb[7:3] = 5'd0;
            cycle($urandom_range(0, 1) == 1, rb, $urandom_range(0, 59) == 0);
        end
        idle(2);

        // Asynchronous reset in the middle of a word
        cycle(1'b0, 8'h00, 1'b1);
        send(8'h18, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("async");
        m_reset_one(0);
        m_reset_one(1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h00, 0); send(8'h00, 2);
        chk("async_b_cnt", 32'(b_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
